// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM address/data, downstream stall/redirect, and the IF/ID register outputs.
interface inst_fetch_if #(
  parameter int unsigned ADDR_W = 6
);
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic [ADDR_W-1:0] pc;
  logic              id_valid;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] id_pc_plus1;
  logic [31:0]       id_inst;
  logic              id_jump_done;

  modport master (
    input  stall, redirect, redirect_pc, rom_inst,
    output rom_addr, pc, id_valid, id_pc, id_pc_plus1, id_inst, id_jump_done
  );

  modport slave (
    output stall, redirect, redirect_pc, rom_inst,
    input  rom_addr, pc, id_valid, id_pc, id_pc_plus1, id_inst, id_jump_done
  );
endinterface

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: PC, async ROM address, IF/ID register, stall and redirect handling.
// Optional macro JUMP_PREDECODE_EN: unconditional jumps are redirected in fetch with no bubble.
module inst_fetch_stage #(
  parameter int unsigned       ADDR_W   = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  inst_fetch_if.master  bus
);

  localparam logic [5:0] JUMP_OP = 6'b010010;

  typedef enum logic {BOOT, RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_plus1;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] idpc_q, idpc_d;
  logic [ADDR_W-1:0] idpc1_q, idpc1_d;
  logic [31:0]       inst_q, inst_d;
`ifdef JUMP_PREDECODE_EN
  logic              jd_q, jd_d;
  logic              is_jump;
`endif

  assign pc_plus1 = pc_q + ADDR_W'(1);

`ifdef JUMP_PREDECODE_EN
  assign is_jump = (bus.rom_inst[31:26] == JUMP_OP);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    pc_d    = pc_q;
    valid_d = valid_q;
    idpc_d  = idpc_q;
    idpc1_d = idpc1_q;
    inst_d  = inst_q;
`ifdef JUMP_PREDECODE_EN
    jd_d    = jd_q;
`endif
    // BOOT commits nothing; redirect beats stall beats normal fetch.
    if (state_q == RUN) begin
      if (bus.redirect) begin
        pc_d    = bus.redirect_pc;
        valid_d = 1'b0;
        inst_d  = '0;
`ifdef JUMP_PREDECODE_EN
        jd_d    = 1'b0;
`endif
      end else if (!bus.stall) begin
        inst_d  = bus.rom_inst;
        idpc_d  = pc_q;
        idpc1_d = pc_plus1;
        valid_d = 1'b1;
`ifdef JUMP_PREDECODE_EN
        if (is_jump) begin
          pc_d = bus.rom_inst[ADDR_W-1:0];
          jd_d = 1'b1;
        end else begin
          pc_d = pc_plus1;
          jd_d = 1'b0;
        end
`else
        pc_d    = pc_plus1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      idpc_q  <= '0;
      idpc1_q <= '0;
      inst_q  <= '0;
`ifdef JUMP_PREDECODE_EN
      jd_q    <= 1'b0;
`endif
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      idpc_q  <= idpc_d;
      idpc1_q <= idpc1_d;
      inst_q  <= inst_d;
`ifdef JUMP_PREDECODE_EN
      jd_q    <= jd_d;
`endif
    end
  end

  assign bus.rom_addr    = pc_q;
  assign bus.pc          = pc_q;
  assign bus.id_valid    = valid_q;
  assign bus.id_pc       = idpc_q;
  assign bus.id_pc_plus1 = idpc1_q;
  assign bus.id_inst     = inst_q;
`ifdef JUMP_PREDECODE_EN
  assign bus.id_jump_done = jd_q;
`else
  assign bus.id_jump_done = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_stage.sv
// Self-checking bench for inst_fetch_stage: directed boot-table scenarios plus randomized
// stall/redirect traffic compared against a behavioural fetch model.
module tb_inst_fetch_stage;

  localparam int unsigned AW    = 6;
  localparam int          DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if #(.ADDR_W(AW)) bus();

  inst_fetch_stage #(.ADDR_W(AW), .RESET_PC(6'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] rom [DEPTH];
  assign bus.rom_inst = rom[bus.rom_addr];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef JUMP_PREDECODE_EN
  localparam bit PREDECODE = 1'b1;
`else
  localparam bit PREDECODE = 1'b0;
`endif

  // Behavioural model state
  bit          m_boot;
  int          m_pc;
  bit          m_valid;
  int          m_idpc, m_idpc1;
  logic [31:0] m_inst;
  bit          m_jd;

  function automatic bit is_jump(input logic [31:0] w);
    return w[31:26] == 6'b010010;
  endfunction

  task automatic model_reset();
    m_boot = 1; m_pc = 0; m_valid = 0; m_idpc = 0; m_idpc1 = 0; m_inst = '0; m_jd = 0;
  endtask

  // Advance the model over one clock edge using the inputs present just before it.
  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) model_reset();
    else if (m_boot) m_boot = 0;
    else if (bus.redirect) begin
      m_pc = int'(bus.redirect_pc); m_valid = 0; m_inst = '0; m_jd = 0;
    end else if (!bus.stall) begin
      w       = rom[m_pc];
      m_inst  = w;
      m_idpc  = m_pc;
      m_idpc1 = (m_pc + 1) % DEPTH;
      m_valid = 1;
      if (PREDECODE && is_jump(w)) begin
        m_pc = int'(w[5:0]); m_jd = 1;
      end else begin
        m_pc = (m_pc + 1) % DEPTH; m_jd = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    rst_n = 0;
    #1;
    model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    bus.stall = 0; bus.redirect = 0; bus.redirect_pc = '0;
    rst_n = 0;
    model_reset();
    tick(); tick(); tick();
    n_checks++;
    if (bus.pc !== 6'h00 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 ||
        bus.id_pc !== 6'h00 || bus.id_pc_plus1 !== 6'h00 || bus.id_jump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: pc=%h valid=%b inst=%h idpc=%h idpc1=%h jd=%b, required all zero",
               bus.pc, bus.id_valid, bus.id_inst, bus.id_pc, bus.id_pc_plus1, bus.id_jump_done);
    end
    rst_n = 1;
    tick();
    n_checks++;
    if (bus.pc !== 6'h00 || bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_edge: pc=%h valid=%b, required pc=00 valid=0", bus.pc, bus.id_valid);
    end
    tick();
    n_checks++;
    if (bus.id_pc !== 6'h00 || bus.id_inst !== 32'h0 || bus.pc !== 6'h01 || bus.id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_fetch: idpc=%h inst=%h pc=%h valid=%b, required 00 00000000 01 1",
               bus.id_pc, bus.id_inst, bus.pc, bus.id_valid);
    end
    tick();
    n_checks++;
    if (bus.id_pc !== 6'h01 || bus.id_inst !== 32'h28033046 || bus.id_pc_plus1 !== 6'h02) begin
      n_fail++;
      $display("FAIL second_fetch: idpc=%h inst=%h idpc1=%h, required 01 28033046 02",
               bus.id_pc, bus.id_inst, bus.id_pc_plus1);
    end
  endtask

  task automatic test_free_run();
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      n_checks++;
      if (bus.id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL free_run_valid: id_valid=%b, required 1", bus.id_valid);
      end
      if (bus.id_pc === 6'h06) begin
        seen = 1;
        n_checks++;
        if (bus.id_inst !== 32'h3c000c21) begin
          n_fail++;
          $display("FAIL free_run_w6: inst=%h, required 3c000c21", bus.id_inst);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL free_run_timeout: id_pc=06 never reached, last id_pc=%h", bus.id_pc);
    end
  endtask

  task automatic test_jump();
    // Continues from id_pc=06, pc=07 (jump word 48000001 fetched on this edge).
    tick();
    n_checks++;
    if (bus.id_inst !== 32'h48000001 || bus.id_pc !== 6'h07) begin
      n_fail++;
      $display("FAIL jump_capture: inst=%h idpc=%h, required 48000001 07", bus.id_inst, bus.id_pc);
    end
    n_checks++;
    if (PREDECODE) begin
      if (bus.pc !== 6'h01 || bus.id_jump_done !== 1'b1) begin
        n_fail++;
        $display("FAIL jump_predecode: pc=%h jd=%b, required 01 1", bus.pc, bus.id_jump_done);
      end
    end else begin
      if (bus.pc !== 6'h08 || bus.id_jump_done !== 1'b0) begin
        n_fail++;
        $display("FAIL jump_plain: pc=%h jd=%b, required 08 0", bus.pc, bus.id_jump_done);
      end
    end
  endtask

  task automatic test_stall();
    bit ok = 0;
    do_reset();
    for (int i = 0; i < 12 && !ok; i++) begin
      tick();
      if (bus.pc === 6'h04) ok = 1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL stall_timeout: pc=04 never reached, pc=%h", bus.pc);
    end
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (bus.pc !== 6'h04 || bus.id_pc !== 6'h03 || bus.id_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h idpc=%h valid=%b, required 04 03 1",
                 i, bus.pc, bus.id_pc, bus.id_valid);
      end
    end
    bus.stall = 0;
    tick();
    n_checks++;
    if (bus.id_pc !== 6'h04 || bus.pc !== 6'h05) begin
      n_fail++;
      $display("FAIL stall_release: idpc=%h pc=%h, required 04 05", bus.id_pc, bus.pc);
    end
  endtask

  task automatic test_redirect_over_stall();
    bus.stall = 1; bus.redirect = 1; bus.redirect_pc = 6'h0A;
    tick();
    n_checks++;
    if (bus.pc !== 6'h0A || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.id_jump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_flush: pc=%h valid=%b inst=%h jd=%b, required 0a 0 00000000 0",
               bus.pc, bus.id_valid, bus.id_inst, bus.id_jump_done);
    end
    bus.stall = 0; bus.redirect = 0;
    tick();
    n_checks++;
    if (bus.id_inst !== 32'h04100841 || bus.id_pc !== 6'h0A || bus.id_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_target: inst=%h idpc=%h valid=%b, required 04100841 0a 1",
               bus.id_inst, bus.id_pc, bus.id_valid);
    end
  endtask

  task automatic test_wrap();
    bus.redirect = 1; bus.redirect_pc = 6'h3F;
    tick();
    bus.redirect = 0;
    n_checks++;
    if (bus.pc !== 6'h3F || bus.rom_addr !== 6'h3F) begin
      n_fail++;
      $display("FAIL wrap_redirect: pc=%h rom_addr=%h, required 3f 3f", bus.pc, bus.rom_addr);
    end
    tick();
    n_checks++;
    if (bus.id_pc !== 6'h3F || bus.pc !== 6'h00 || bus.id_pc_plus1 !== 6'h00) begin
      n_fail++;
      $display("FAIL wrap: idpc=%h pc=%h idpc1=%h, required 3f 00 00", bus.id_pc, bus.pc, bus.id_pc_plus1);
    end
  endtask

  task automatic test_midrun_reset();
    tick(); tick();
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if (bus.pc !== 6'h00 || bus.id_valid !== 1'b0 || bus.id_inst !== 32'h0 || bus.id_pc !== 6'h00) begin
      n_fail++;
      $display("FAIL midrun_reset: pc=%h valid=%b inst=%h idpc=%h, required all zero",
               bus.pc, bus.id_valid, bus.id_inst, bus.id_pc);
    end
    tick();
    rst_n = 1;
    tick();
    n_checks++;
    if (bus.pc !== 6'h00 || bus.id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_boot: pc=%h valid=%b, required 00 0", bus.pc, bus.id_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.stall       = ($urandom_range(3) == 0);
      bus.redirect    = ($urandom_range(9) == 0);
      bus.redirect_pc = AW'($urandom_range(DEPTH - 1));
      tick();
      n_checks++;
      if (bus.pc !== AW'(m_pc) || bus.rom_addr !== AW'(m_pc) || bus.id_valid !== m_valid ||
          bus.id_pc !== AW'(m_idpc) || bus.id_pc_plus1 !== AW'(m_idpc1) ||
          bus.id_inst !== m_inst || bus.id_jump_done !== m_jd) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h v=%b idpc=%h idpc1=%h inst=%h jd=%b, required %h %b %h %h %h %b",
                 i, bus.pc, bus.id_valid, bus.id_pc, bus.id_pc_plus1, bus.id_inst, bus.id_jump_done,
                 AW'(m_pc), m_valid, AW'(m_idpc), AW'(m_idpc1), m_inst, m_jd);
      end
    end
    bus.stall = 0; bus.redirect = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
    rom[0] = 32'h0;
    for (int i = 2; i <= 5; i++) if (is_jump(rom[i])) rom[i][26] = 1'b1;
    if (is_jump(rom[63])) rom[63][26] = 1'b1;
    rom[1]  = 32'h28033046;
    rom[6]  = 32'h3c000c21;
    rom[7]  = 32'h48000001;
    rom[8]  = 32'h00100421;
    rom[9]  = 32'h00100421;
    rom[10] = 32'h04100841;

    test_reset();
    test_free_run();
    test_jump();
    test_stall();
    test_redirect_over_stall();
    test_wrap();
    test_midrun_reset();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
